// File: rtl/tlv5618_update_ctrl.sv
// Update sequencer for the TLV5618 serial DAC driver: turns a channel-A/B update
// request into one or two command frames, with a one-deep pending request slot.
module tlv5618_update_ctrl #(
    parameter int GAP_CYC = 4,
    parameter int TMO_CYC = 4096
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Upd_Req,
    input  logic [1:0]  Chan_Sel,
    input  logic [11:0] Data_A,
    input  logic [11:0] Data_B,
    input  logic        Speed,
    input  logic        Pwr_Dn,
    output logic        Busy,
    output logic        Upd_Done,
    output logic        Ovr,
    output logic        Tmo_Err,
    output logic [15:0] DAC_DATA,
    output logic        Start,
    input  logic        Set_Done,
    input  logic        DAC_State
);

    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GAP       = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [11:0] code_a;
        logic [11:0] code_b;
        logic        spd;
        logic        pwr;
    } req_t;

    // Word layout: R1, SPD, PWR, R0, 12-bit code.
    function automatic logic [15:0] build_word(
        input logic        r1,
        input logic        r0,
        input logic        spd,
        input logic        pwr,
        input logic [11:0] code
    );
        return {r1, spd, pwr, r0, code};
    endfunction

    state_t           r_state;
    req_t             r_req;
    req_t             r_pend;
    logic             r_pend_vld;
    logic             r_second;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_busy;
    logic             r_upd_done;
    logic             r_ovr;
    logic             r_tmo_err;
    logic             r_start;
    logic [15:0]      r_dac_data;

    req_t             w_in;
    logic             w_new_req;
    logic             w_two_frames;
    logic [15:0]      w_word;

    assign w_in         = {Chan_Sel, Data_A, Data_B, Speed, Pwr_Dn};
    assign w_new_req    = Upd_Req && (Chan_Sel != 2'b00);
    assign w_two_frames = (r_req.sel == 2'b11);

    // Command word for the frame about to be loaded; for A+B the buffer write goes first
    always_comb begin
        w_word = 16'h0000;
        case (r_req.sel)
            2'b10: w_word = build_word(1'b0, 1'b0, r_req.spd, r_req.pwr, r_req.code_b);
            2'b01: w_word = build_word(1'b1, 1'b0, r_req.spd, r_req.pwr, r_req.code_a);
            2'b11: begin
                if (r_second) begin
                    w_word = build_word(1'b1, 1'b0, r_req.spd, r_req.pwr, r_req.code_a);
                end else begin
                    w_word = build_word(1'b0, 1'b1, r_req.spd, r_req.pwr, r_req.code_b);
                end
            end
            default: w_word = 16'h0000;
        endcase
    end

    // Sequencer FSM, pending slot and all registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state    <= ST_IDLE;
            r_req      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_second   <= 1'b0;
            r_gap_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_busy     <= 1'b0;
            r_upd_done <= 1'b0;
            r_ovr      <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_start    <= 1'b0;
            r_dac_data <= 16'h0000;
        end else begin
            r_start    <= 1'b0;
            r_upd_done <= 1'b0;
            r_ovr      <= 1'b0;

            // A request arriving while the slot drains in IDLE refills it without overrun
            if (r_state == ST_IDLE) begin
                if (r_pend_vld) begin
                    r_pend_vld <= w_new_req;
                    if (w_new_req) begin
                        r_pend <= w_in;
                    end
                end
            end else if (w_new_req) begin
                r_pend     <= w_in;
                r_pend_vld <= 1'b1;
                r_ovr      <= r_pend_vld;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pend_vld || w_new_req) begin
                        r_req     <= r_pend_vld ? r_pend : w_in;
                        r_busy    <= 1'b1;
                        r_tmo_err <= 1'b0;
                        r_second  <= 1'b0;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!DAC_State) begin
                        r_gap_cnt <= '0;
                    end else if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt  <= '0;
                        r_dac_data <= w_word;
                        r_start    <= 1'b1;
                        r_state    <= ST_LOAD;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1'b1);
                    end
                end
                ST_LOAD: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (Set_Done) begin
                        r_state <= ST_NEXT;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_tmo_err <= 1'b1;
                        r_state   <= ST_FINISH;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1'b1);
                    end
                end
                ST_NEXT: begin
                    if (w_two_frames && !r_second) begin
                        r_second <= 1'b1;
                        r_state  <= ST_GAP;
                    end else begin
                        r_upd_done <= 1'b1;
                        r_state    <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy     = r_busy;
    assign Upd_Done = r_upd_done;
    assign Ovr      = r_ovr;
    assign Tmo_Err  = r_tmo_err;
    assign DAC_DATA = r_dac_data;
    assign Start    = r_start;

endmodule

// File: tb/tb_tlv5618_update_ctrl.sv
// Scoreboard bench for tlv5618_update_ctrl with a behavioural TLV5618 driver model.
module tb_tlv5618_update_ctrl;

    localparam int GAP_CYC = 4;
    localparam int TMO_CYC = 4096;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Upd_Req = 1'b0;
    logic [1:0]  Chan_Sel = 2'b00;
    logic [11:0] Data_A = 12'h000;
    logic [11:0] Data_B = 12'h000;
    logic        Speed = 1'b0;
    logic        Pwr_Dn = 1'b0;
    logic        Busy;
    logic        Upd_Done;
    logic        Ovr;
    logic        Tmo_Err;
    logic [15:0] DAC_DATA;
    logic        Start;
    logic        Set_Done;
    logic        DAC_State;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_frames[$];
    logic [15:0] exp_done[$];
    int          ovr_seen = 0;
    bit          drv_hang = 1'b0;
    bit          glitch_en = 1'b0;
    int          drv_cnt;
    int          mon_hi_cnt = 0;
    bit          mon_in_frame = 1'b0;
    logic [15:0] mon_last_word = 16'h0000;

    tlv5618_update_ctrl #(.GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Upd_Req(Upd_Req), .Chan_Sel(Chan_Sel),
        .Data_A(Data_A), .Data_B(Data_B), .Speed(Speed), .Pwr_Dn(Pwr_Dn),
        .Busy(Busy), .Upd_Done(Upd_Done), .Ovr(Ovr), .Tmo_Err(Tmo_Err),
        .DAC_DATA(DAC_DATA), .Start(Start), .Set_Done(Set_Done), .DAC_State(DAC_State)
    );

    always #5 Clk = ~Clk;

    // Driver model: CS_N low for a random frame length after Start, then Set_Done
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            DAC_State <= 1'b1;
            Set_Done  <= 1'b0;
            drv_cnt   <= 0;
        end else begin
            Set_Done <= 1'b0;
            if (drv_cnt > 0) begin
                drv_cnt <= drv_cnt - 1;
                if (drv_cnt == 1) begin
                    DAC_State <= 1'b1;
                    Set_Done  <= !drv_hang;
                end
            end else if (Start) begin
                DAC_State <= 1'b0;
                drv_cnt   <= drv_hang ? 20 : int'($urandom_range(2, 10));
            end else if (!DAC_State) begin
                DAC_State <= 1'b1;
            end else if (glitch_en && ($urandom_range(0, 7) == 0)) begin
                DAC_State <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_word(input int r1, input int r0, input int spd,
                                            input int pwr, input int code);
        return 16'(r1 * 32768 + spd * 16384 + pwr * 8192 + r0 * 4096 + code);
    endfunction

    // Reference: frames a request must produce and the word that precedes its Upd_Done
    task automatic expect_req(input int sel, input int a, input int b, input int spd, input int pwr);
        if (sel == 2) begin
            exp_frames.push_back(mk_word(0, 0, spd, pwr, b));
            exp_done.push_back(mk_word(0, 0, spd, pwr, b));
        end else if (sel == 1) begin
            exp_frames.push_back(mk_word(1, 0, spd, pwr, a));
            exp_done.push_back(mk_word(1, 0, spd, pwr, a));
        end else if (sel == 3) begin
            exp_frames.push_back(mk_word(0, 1, spd, pwr, b));
            exp_frames.push_back(mk_word(1, 0, spd, pwr, a));
            exp_done.push_back(mk_word(1, 0, spd, pwr, a));
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input int sel, input int a, input int b, input int spd, input int pwr);
        Chan_Sel = 2'(sel);
        Data_A   = 12'(a);
        Data_B   = 12'(b);
        Speed    = 1'(spd);
        Pwr_Dn   = 1'(pwr);
        Upd_Req  = 1'b1;
        step();
        Upd_Req  = 1'b0;
        Data_A   = 12'($urandom);
        Data_B   = 12'($urandom);
        Speed    = 1'($urandom);
        Pwr_Dn   = 1'($urandom);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_frames.size() != 0 || exp_done.size() != 0 || Busy) && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s: drain timeout, %0d frames and %0d dones still expected",
                     name, exp_frames.size(), exp_done.size());
        end
        repeat (GAP_CYC + 2) step();
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!Start && n < 200) begin
            step();
            n++;
        end
        check(name, int'(Start), 1);
    endtask

    // Burst of k requests: first accepted, second pends, later ones overwrite the slot
    task automatic burst(input int k);
        int sel[4];
        int a[4];
        int b[4];
        int spd[4];
        int pwr[4];
        int ovr0;
        ovr0 = ovr_seen;
        for (int i = 0; i < k; i++) begin
            sel[i] = int'($urandom_range(1, 3));
            a[i]   = int'($urandom_range(0, 4095));
            b[i]   = int'($urandom_range(0, 4095));
            spd[i] = int'($urandom_range(0, 1));
            pwr[i] = int'($urandom_range(0, 1));
        end
        expect_req(sel[0], a[0], b[0], spd[0], pwr[0]);
        for (int i = 0; i < k; i++) begin
            issue(sel[i], a[i], b[i], spd[i], pwr[i]);
            if ($urandom_range(0, 1) == 1) step();
        end
        if (k >= 2) expect_req(sel[k-1], a[k-1], b[k-1], spd[k-1], pwr[k-1]);
        drain("burst");
        check("ovr_count", ovr_seen - ovr0, (k > 2) ? k - 2 : 0);
    endtask

    // Monitor: pops the scoreboard on Start/Upd_Done and checks CS_N gap and data hold
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge Clk);
            if (!Rst_n) begin
                mon_hi_cnt   = 0;
                mon_in_frame = 1'b0;
            end else begin
                if (Start) begin
                    checks++;
                    if (mon_hi_cnt < GAP_CYC) begin
                        errors++;
                        $display("FAIL cs_gap: CS_N high %0d cycles before Start, need %0d",
                                 mon_hi_cnt, GAP_CYC);
                    end
                    if (exp_frames.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame: unexpected Start with word %h, none expected", DAC_DATA);
                    end else begin
                        e = exp_frames.pop_front();
                        check("frame_word", int'(DAC_DATA), int'(e));
                    end
                    mon_last_word = DAC_DATA;
                    mon_in_frame  = 1'b1;
                end else if (mon_in_frame) begin
                    check("data_hold", int'(DAC_DATA), int'(mon_last_word));
                end
                if (Set_Done || !Busy) mon_in_frame = 1'b0;
                if (Upd_Done) begin
                    if (exp_done.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL upd_done: unexpected pulse after word %h, none expected",
                                 mon_last_word);
                    end else begin
                        e = exp_done.pop_front();
                        check("done_after", int'(mon_last_word), int'(e));
                    end
                end
                if (Ovr) ovr_seen++;
                mon_hi_cnt = DAC_State ? mon_hi_cnt + 1 : 0;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit busy_seen;

        // Reset values
        repeat (3) @(posedge Clk);
        #1;
        check("reset_ctrl", int'({Busy, Upd_Done, Ovr, Tmo_Err, Start}), 0);
        check("reset_data", int'(DAC_DATA), 0);
        Rst_n = 1'b1;
        repeat (GAP_CYC + 2) step();

        // B-only with exact request-to-Start latency
        exp_frames.push_back(16'h45A5);
        exp_done.push_back(16'h45A5);
        Chan_Sel = 2'b10;
        Data_B   = 12'h5A5;
        Data_A   = 12'h3C7;
        Speed    = 1'b1;
        Pwr_Dn   = 1'b0;
        Upd_Req  = 1'b1;
        n = 0;
        while (!Start && n < 50) begin
            step();
            n++;
            Upd_Req = 1'b0;
        end
        Upd_Req = 1'b0;
        check("start_latency", n, 1 + GAP_CYC);
        drain("b_only");

        // Both channels: buffer write then A
        exp_frames.push_back(16'h1001);
        exp_frames.push_back(16'h8FFF);
        exp_done.push_back(16'h8FFF);
        issue(3, 12'hFFF, 12'h001, 0, 0);
        drain("both");

        // Three requests back to back: one overrun, only the last pending is sent
        burst(3);

        // Driver never returns Set_Done
        drv_hang = 1'b1;
        exp_frames.push_back(16'h03C3);
        issue(2, 12'h111, 12'h3C3, 0, 0);
        wait_start("tmo_start_seen");
        n = 0;
        while (!Tmo_Err && n < TMO_CYC + 100) begin
            step();
            n++;
        end
        checks++;
        if (n < TMO_CYC || n > TMO_CYC + 2) begin
            errors++;
            $display("FAIL tmo_latency: Tmo_Err %0d cycles after Start, expected %0d..%0d",
                     n, TMO_CYC, TMO_CYC + 2);
        end
        repeat (2) step();
        check("tmo_busy_low", int'(Busy), 0);
        repeat (10) step();
        check("tmo_sticky", int'(Tmo_Err), 1);
        drv_hang = 1'b0;

        // A-only with power-down after a timeout: clears Tmo_Err and completes
        exp_frames.push_back(16'hA800);
        exp_done.push_back(16'hA800);
        issue(1, 12'h800, 12'h456, 0, 1);
        check("tmo_cleared", int'(Tmo_Err), 0);
        check("busy_on_accept", int'(Busy), 1);
        drain("a_only");

        // Chan_Sel=00 in idle is a no-op
        busy_seen = 1'b0;
        issue(0, 12'h123, 12'h456, 1, 1);
        for (int i = 0; i < 20; i++) begin
            busy_seen = busy_seen | Busy;
            step();
        end
        check("noop_busy", int'(busy_seen), 0);

        // Asynchronous reset while waiting for Set_Done
        exp_frames.push_back(16'h1ABC);
        exp_frames.push_back(16'h8DEF);
        exp_done.push_back(16'h8DEF);
        issue(3, 12'hDEF, 12'hABC, 0, 0);
        wait_start("rst_start_seen");
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        check("midframe_rst_ctrl", int'({Busy, Upd_Done, Ovr, Tmo_Err, Start}), 0);
        check("midframe_rst_data", int'(DAC_DATA), 0);
        exp_frames.delete();
        exp_done.delete();
        step();
        Rst_n = 1'b1;
        repeat (GAP_CYC + 2) step();
        expect_req(2, 12'h000, 12'h7E1, 1, 1);
        issue(2, 12'h000, 12'h7E1, 1, 1);
        drain("after_reset");

        // Randomized bursts with CS_N glitches on an idle driver
        glitch_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            burst(int'($urandom_range(1, 4)));
            repeat ($urandom_range(0, 5)) step();
        end
        glitch_en = 1'b0;
        drain("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
